// File: rtl/sw_key_debounce_lbus.sv
// rtl/sw_key_debounce_lbus.sv - debounced key/switch peripheral with event flags on the XT local bus
//
// Ports:
//   lb_clk   - bus/peripheral clock (single clock domain)
//   rst_n    - synchronous active-low reset
//   xt_lb    - local bus slave view (addr[2:0], wdata, qualified write strobe we)
//   rdata    - combinational read data selected by xt_lb.addr[2:0]
//   irq      - level interrupt (enabled KEY_PRESS bits, or any SW_CHANGE when enabled)
//   key_raw  - asynchronous key pins
//   sw_raw   - asynchronous switch pins

package xt_lb_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
    } lb_slave_t;
endpackage

module sw_key_debounce_lbus
    import xt_lb_pkg::*;
#(
    parameter int KEY_NUM        = 4,
    parameter int SW_NUM         = 3,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_TICKS   = 8
) (
    input  logic                lb_clk,
    input  logic                rst_n,
    input  lb_slave_t           xt_lb,
    output logic [15:0]         rdata,
    output logic                irq,
    input  logic [KEY_NUM-1:0]  key_raw,
    input  logic [SW_NUM-1:0]   sw_raw
);

    localparam int N  = KEY_NUM + SW_NUM;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [2:0] A_KEY_STATE   = 3'd0;
    localparam logic [2:0] A_SW_STATE    = 3'd1;
    localparam logic [2:0] A_KEY_PRESS   = 3'd2;
    localparam logic [2:0] A_KEY_RELEASE = 3'd3;
    localparam logic [2:0] A_SW_CHANGE   = 3'd4;
    localparam logic [2:0] A_IRQ_EN      = 3'd5;

    // Upper address and data bits are not decoded by this slave.
    logic w_unused;
    assign w_unused = ^{xt_lb.addr[15:3], xt_lb.wdata};

    // Keys occupy the low bits of the combined vector, switches the high bits.
    logic [N-1:0] w_in;
    assign w_in = {sw_raw, (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw};

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
        end
    end

    // Shared prescaler: tick is high for the single cycle the count sits at TICK_DIV-1.
    logic [PW-1:0] r_pre;
    logic          w_tick;
    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge lb_clk) begin
        if (!rst_n)      r_pre <= '0;
        else if (w_tick) r_pre <= '0;
        else             r_pre <= r_pre + 1'b1;
    end

    // Debounce: a new level is only accepted after STABLE_TICKS consecutive
    // ticks that disagree with the current level; any agreeing tick restarts.
    logic [N-1:0]  r_d;
    logic [CW-1:0] r_c [N];
    logic [N-1:0]  w_d_next;
    logic [CW-1:0] w_c_next [N];

    always_comb begin
        w_d_next = r_d;
        for (int i = 0; i < N; i++) begin
            w_c_next[i] = r_c[i];
            if (w_tick) begin
                if (r_s2[i] == r_d[i]) begin
                    w_c_next[i] = '0;
                end else if (r_c[i] == CW'(STABLE_TICKS - 1)) begin
                    w_d_next[i] = r_s2[i];
                    w_c_next[i] = '0;
                end else begin
                    w_c_next[i] = r_c[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            r_d <= '0;
            for (int i = 0; i < N; i++) r_c[i] <= '0;
        end else begin
            r_d <= w_d_next;
            for (int i = 0; i < N; i++) r_c[i] <= w_c_next[i];
        end
    end

    // Edges are taken from the next-state value so flags land on the same edge as d.
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    assign w_rise = w_d_next & ~r_d;
    assign w_fall = ~w_d_next & r_d;

    logic w_wr_press, w_wr_release, w_wr_change, w_wr_en;
    assign w_wr_press   = xt_lb.we && (xt_lb.addr[2:0] == A_KEY_PRESS);
    assign w_wr_release = xt_lb.we && (xt_lb.addr[2:0] == A_KEY_RELEASE);
    assign w_wr_change  = xt_lb.we && (xt_lb.addr[2:0] == A_SW_CHANGE);
    assign w_wr_en      = xt_lb.we && (xt_lb.addr[2:0] == A_IRQ_EN);

    logic [KEY_NUM-1:0] w_clr_press, w_clr_release;
    logic [SW_NUM-1:0]  w_clr_change;
    assign w_clr_press   = w_wr_press   ? xt_lb.wdata[KEY_NUM-1:0] : '0;
    assign w_clr_release = w_wr_release ? xt_lb.wdata[KEY_NUM-1:0] : '0;
    assign w_clr_change  = w_wr_change  ? xt_lb.wdata[SW_NUM-1:0]  : '0;

    logic [KEY_NUM-1:0] r_press;
    logic [KEY_NUM-1:0] r_release;
    logic [SW_NUM-1:0]  r_change;
    logic [KEY_NUM-1:0] r_en_key;
    logic               r_en_sw;

    // Set is OR-ed in after the clear, so a coincident edge always survives.
    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            r_press   <= '0;
            r_release <= '0;
            r_change  <= '0;
            r_en_key  <= '0;
            r_en_sw   <= 1'b0;
        end else begin
            r_press   <= (r_press   & ~w_clr_press)   | w_rise[KEY_NUM-1:0];
            r_release <= (r_release & ~w_clr_release) | w_fall[KEY_NUM-1:0];
            r_change  <= (r_change  & ~w_clr_change)
                         | w_rise[N-1:KEY_NUM] | w_fall[N-1:KEY_NUM];
            if (w_wr_en) begin
                r_en_key <= xt_lb.wdata[KEY_NUM-1:0];
                r_en_sw  <= xt_lb.wdata[15];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (xt_lb.addr[2:0])
            A_KEY_STATE:   rdata[KEY_NUM-1:0] = r_d[KEY_NUM-1:0];
            A_SW_STATE:    rdata[SW_NUM-1:0]  = r_d[N-1:KEY_NUM];
            A_KEY_PRESS:   rdata[KEY_NUM-1:0] = r_press;
            A_KEY_RELEASE: rdata[KEY_NUM-1:0] = r_release;
            A_SW_CHANGE:   rdata[SW_NUM-1:0]  = r_change;
            A_IRQ_EN: begin
                rdata[KEY_NUM-1:0] = r_en_key;
                rdata[15]          = r_en_sw;
            end
            default:       rdata = '0;
        endcase
    end

    assign irq = (|(r_press & r_en_key)) | (r_en_sw & (|r_change));

endmodule

// File: tb/tb_sw_key_debounce_lbus.sv
// tb/tb_sw_key_debounce_lbus.sv - scoreboard bench for sw_key_debounce_lbus
module tb_sw_key_debounce_lbus;
    import xt_lb_pkg::*;

    logic        lb_clk = 1'b0;
    logic        rst_n;
    lb_slave_t   lb;
    logic [15:0] rdata;
    logic        irq;
    logic [3:0]  key_raw;
    logic [2:0]  sw_raw;

    sw_key_debounce_lbus #(
        .KEY_NUM(4), .SW_NUM(3), .KEY_ACTIVE_LOW(1), .TICK_DIV(4), .STABLE_TICKS(3)
    ) dut (
        .lb_clk(lb_clk), .rst_n(rst_n), .xt_lb(lb), .rdata(rdata), .irq(irq),
        .key_raw(key_raw), .sw_raw(sw_raw)
    );

    always #10 lb_clk = ~lb_clk;

    // Edges counted since reset release; prescaler ticks on every 4th such edge.
    int ecount = 0;
    always @(posedge lb_clk) if (rst_n) ecount <= ecount + 1;

    typedef struct {
        string       tag;
        logic [2:0]  addr;
        logic [15:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        lb.addr = {13'd0, a};
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        lb.addr  = {13'd0, a};
        lb.wdata = d;
        lb.we    = 1'b1;
        step();
        lb.we    = 1'b0;
    endtask

    task automatic push(input string tag, input logic [2:0] a, input logic [15:0] e);
        sb_t s;
        s.tag = tag; s.addr = a; s.exp = e;
        sb.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        logic [15:0] v;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rd(s.addr, v);
            check(s.tag, v, s.exp);
        end
    endtask

    initial begin
        logic [15:0] v;
        int n, k1, kd;
        bit found;

        lb = '0; key_raw = 4'hF; sw_raw = 3'b000; rst_n = 1'b0;
        repeat (2) @(posedge lb_clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 8; a++) push($sformatf("reset_addr%0d", a), 3'(a), 16'h0000);
        drain();
        check("reset_irq", {15'd0, irq}, 16'd0);

        // Key 0 press: debounced within 2 sync + 12 cycles, no sooner than 2 + 9.
        key_raw = 4'hE;
        found = 0; n = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            step();
            rd(3'd0, v);
            if (v == 16'h0001) begin found = 1; n = i; end
        end
        check("press_latency", {15'd0, found && n >= 11 && n <= 14}, 16'd1);
        push("press_flag", 3'd2, 16'h0001);
        drain();
        step();
        push("press_flag_next", 3'd2, 16'h0001);
        drain();

        // Glitch on key 1 for 8 cycles (2 ticks) must never be accepted.
        key_raw = 4'hC;
        repeat (8) step();
        key_raw = 4'hE;
        repeat (20) step();
        push("glitch_state", 3'd0, 16'h0001);
        push("glitch_press", 3'd2, 16'h0001);
        drain();

        // Enable and clear.
        wr(3'd5, 16'h0001);
        check("irq_enabled", {15'd0, irq}, 16'd1);
        wr(3'd2, 16'h0001);
        push("press_cleared", 3'd2, 16'h0000);
        drain();
        check("irq_cleared", {15'd0, irq}, 16'd0);

        // Release key 0 and wait for it to settle.
        key_raw = 4'hF;
        found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            step();
            rd(3'd0, v);
            if (v == 16'h0000) found = 1;
        end
        check("release_seen", {15'd0, found}, 16'd1);

        // Press again and land the W1C write on the exact debounce edge.
        key_raw = 4'hE;
        k1 = ecount + 3;
        while (k1 % 4 != 0) k1++;
        kd = k1 + 8;
        for (int i = 0; i < 40 && ecount < kd - 1; i++) step();
        rd(3'd0, v);
        check("coll_pre_state", v, 16'h0000);
        wr(3'd2, 16'h0001);
        push("coll_state", 3'd0, 16'h0001);
        push("coll_press", 3'd2, 16'h0001);
        drain();
        check("coll_irq", {15'd0, irq}, 16'd1);

        // Release and switch events.
        wr(3'd3, 16'h000F);
        wr(3'd2, 16'h0001);
        wr(3'd5, 16'h8001);
        check("irq_quiet", {15'd0, irq}, 16'd0);
        key_raw = 4'hF;
        sw_raw  = 3'b101;
        repeat (30) step();
        push("rel_key_state", 3'd0, 16'h0000);
        push("sw_state",      3'd1, 16'h0005);
        push("rel_press",     3'd2, 16'h0000);
        push("key_release",   3'd3, 16'h0001);
        push("sw_change",     3'd4, 16'h0005);
        push("irq_en",        3'd5, 16'h8001);
        push("addr6",         3'd6, 16'h0000);
        push("addr7",         3'd7, 16'h0000);
        drain();
        check("sw_irq", {15'd0, irq}, 16'd1);

        wr(3'd1, 16'hFFFF);
        push("ro_write", 3'd1, 16'h0005);
        drain();
        wr(3'd5, 16'h0001);
        check("sw_irq_masked", {15'd0, irq}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
